// File: rtl/qspi_flash_reader_if.sv
// Request/response bus of the QSPI flash reader.
// The master side issues word reads and the slave side returns the data.
interface qspi_flash_reader_if;
    logic        req_valid;
    logic        req_ready;
    logic [23:0] req_addr;
    logic        resp_valid;
    logic [31:0] resp_data;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  resp_valid,
        input  resp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output resp_valid,
        output resp_data
    );
endinterface

// File: rtl/qspi_flash_reader.sv
// QSPI flash word reader.
// After reset it waits, then sends the 0xAB wake-up command. It then serves
// 32-bit little-endian word reads using Quad Output Fast Read (0x6B).
module qspi_flash_reader #(
    parameter int unsigned DUMMY_CYCLES = 8,
    parameter int unsigned INIT_WAIT    = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    qspi_flash_reader_if.slave        bus,
    output logic                      flash_csn,
    output logic                      flash_sck,
    output logic [3:0]                flash_io_out,
    output logic [3:0]                flash_io_oe,
    input  logic [3:0]                flash_io_in
);
    localparam int unsigned CntW = $clog2(INIT_WAIT + 4);

    typedef enum logic [3:0] {
        StInitWait, StWake, StGap, StIdle, StCmd, StAddr, StDummy, StData, StDone
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [4:0]      cyc_q, cyc_d;
    logic [31:0]     sh_q, sh_d;
    logic [27:0]     rx_q, rx_d;
    logic            csn_q, csn_d;
    logic            sck_q, sck_d;
    logic [3:0]      io_out_q, io_out_d;
    logic [3:0]      io_oe_q, io_oe_d;
    logic            ready_q, ready_d;
    logic            resp_valid_q, resp_valid_d;
    logic [31:0]     resp_data_q, resp_data_d;
    logic [31:0]     word;

    // Nibble stream including the nibble sampled on this edge; first nibble on top.
    assign word = {rx_q, flash_io_in};

    // Next-state and registered-output logic; an SCK cycle ends on the edge where sck_q is 1.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cyc_d        = cyc_q;
        sh_d         = sh_q;
        rx_d         = rx_q;
        csn_d        = csn_q;
        sck_d        = sck_q;
        io_out_d     = io_out_q;
        io_oe_d      = io_oe_q;
        ready_d      = ready_q;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;

        case (state_q)
            StInitWait: begin
                if (cnt_q == CntW'(INIT_WAIT - 1)) begin
                    state_d  = StWake;
                    cnt_d    = '0;
                    cyc_d    = '0;
                    csn_d    = 1'b0;
                    io_oe_d  = 4'b0001;
                    io_out_d = 4'b0001;                // bit 7 of 0xAB
                    sh_d     = {8'hAB, 24'h000000} << 1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWake, StCmd, StAddr: begin
                sck_d = ~sck_q;
                if (sck_q) begin
                    if (state_q == StWake && cyc_q == 5'd7) begin
                        state_d  = StGap;
                        cnt_d    = '0;
                        csn_d    = 1'b1;
                        sck_d    = 1'b0;
                        io_oe_d  = 4'b0000;
                        io_out_d = 4'b0000;
                    end else if (state_q == StAddr && cyc_q == 5'd23) begin
                        state_d  = StDummy;
                        cyc_d    = '0;
                        io_oe_d  = 4'b0000;
                        io_out_d = 4'b0000;
                    end else begin
                        // Command and address form one continuous 32-bit shift.
                        io_out_d = {3'b000, sh_q[31]};
                        sh_d     = {sh_q[30:0], 1'b0};
                        if (state_q == StCmd && cyc_q == 5'd7) begin
                            state_d = StAddr;
                            cyc_d   = '0;
                        end else begin
                            cyc_d = cyc_q + 1'b1;
                        end
                    end
                end
            end
            StDummy: begin
                sck_d = ~sck_q;
                if (sck_q) begin
                    if (cyc_q == 5'(DUMMY_CYCLES - 1)) begin
                        state_d = StData;
                        cyc_d   = '0;
                    end else begin
                        cyc_d = cyc_q + 1'b1;
                    end
                end
            end
            StData: begin
                sck_d = ~sck_q;
                if (sck_q) begin
                    rx_d = word[27:0];
                    if (cyc_q == 5'd7) begin
                        state_d      = StDone;
                        csn_d        = 1'b1;
                        sck_d        = 1'b0;
                        resp_valid_d = 1'b1;
                        resp_data_d  = {word[7:0], word[15:8], word[23:16], word[31:24]};
                    end else begin
                        cyc_d = cyc_q + 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StGap;
                cnt_d   = '0;
            end
            StGap: begin
                if (cnt_q == CntW'(3)) begin
                    state_d = StIdle;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StIdle: begin
                if (bus.req_valid && ready_q) begin
                    state_d  = StCmd;
                    ready_d  = 1'b0;
                    cyc_d    = '0;
                    csn_d    = 1'b0;
                    sck_d    = 1'b0;
                    io_oe_d  = 4'b0001;
                    io_out_d = 4'b0000;                // bit 7 of 0x6B
                    sh_d     = {8'h6B, bus.req_addr} << 1;
                end
            end
            default: state_d = StInitWait;
        endcase
    end

    // State and output registers; reset returns the pins to idle at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StInitWait;
            cnt_q        <= '0;
            cyc_q        <= '0;
            sh_q         <= '0;
            rx_q         <= '0;
            csn_q        <= 1'b1;
            sck_q        <= 1'b0;
            io_out_q     <= 4'b0000;
            io_oe_q      <= 4'b0000;
            ready_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cyc_q        <= cyc_d;
            sh_q         <= sh_d;
            rx_q         <= rx_d;
            csn_q        <= csn_d;
            sck_q        <= sck_d;
            io_out_q     <= io_out_d;
            io_oe_q      <= io_oe_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign flash_csn      = csn_q;
    assign flash_sck      = sck_q;
    assign flash_io_out   = io_out_q;
    assign flash_io_oe    = io_oe_q;
    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
endmodule

// File: tb/tb_qspi_flash_reader.sv
// Bench for qspi_flash_reader: behavioural flash model, table vectors,
// hand-written reset/back-to-back sequences and random reads.
module tb_qspi_flash_reader;
    localparam int unsigned DUMMY = 8;
    localparam int unsigned INITW = 64;
    localparam int NSCK = 40 + DUMMY;
    localparam int LAT  = 2 * (40 + DUMMY) + 1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       flash_csn, flash_sck;
    logic [3:0] flash_io_out, flash_io_oe;
    logic [3:0] flash_io_in = 4'h0;

    qspi_flash_reader_if bus ();

    qspi_flash_reader #(.DUMMY_CYCLES(DUMMY), .INIT_WAIT(INITW)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .flash_csn    (flash_csn),
        .flash_sck    (flash_sck),
        .flash_io_out (flash_io_out),
        .flash_io_oe  (flash_io_oe),
        .flash_io_in  (flash_io_in)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Flash contents: four fixed bytes at 0x012345, a scrambled pattern elsewhere.
    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        case (a)
            24'h012345: return 8'h11;
            24'h012346: return 8'h22;
            24'h012347: return 8'h33;
            24'h012348: return 8'h44;
            default:    return (a[7:0] * 8'd7) ^ a[15:8] ^ {a[19:16], a[23:20]} ^ 8'hA5;
        endcase
    endfunction

    function automatic logic [31:0] expect_word(input logic [23:0] a);
        return {mem_byte(a + 24'd3), mem_byte(a + 24'd2), mem_byte(a + 24'd1), mem_byte(a)};
    endfunction

    // Flash model: counts SCK rises per chip-select, keeps the first 32 IO0 bits,
    // and presents data nibbles after the dummy cycles.
    typedef struct {
        int          nsck;
        logic [31:0] bits;
    } xfer_t;
    xfer_t       log_q[$];
    int          rise_cnt = 0;
    logic [31:0] in_bits = '0;
    int          fk;
    logic [7:0]  fb;

    always @(posedge flash_sck or posedge flash_csn) begin
        if (flash_csn) begin
            if (rise_cnt != 0) log_q.push_back('{nsck: rise_cnt, bits: in_bits});
            rise_cnt = 0;
            in_bits  = '0;
        end else begin
            rise_cnt = rise_cnt + 1;
            if (rise_cnt <= 32) in_bits = {in_bits[30:0], flash_io_out[0]};
            if (rise_cnt > 32 + DUMMY && rise_cnt <= 40 + DUMMY) begin
                fk = rise_cnt - 33 - DUMMY;
                fb = mem_byte(in_bits[23:0] + 24'(fk / 2));
                flash_io_in = (fk % 2 == 0) ? fb[7:4] : fb[3:0];
            end
        end
    end

    // Protocol checker, sampled away from the active edge.
    int   viol = 0;
    int   rv_count = 0;
    logic rv_prev = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            if (flash_csn && flash_sck) begin
                viol = viol + 1;
                $display("checker: sck high while csn high at cycle %0d", cyc);
            end
            if (!flash_csn && (rise_cnt > 32 || (rise_cnt == 32 && !flash_sck)) &&
                flash_io_oe != 4'h0) begin
                viol = viol + 1;
                $display("checker: oe=%h during dummy/data at cycle %0d", flash_io_oe, cyc);
            end
            if ((flash_io_out[3:1] & ~flash_io_oe[3:1]) != 3'b000) begin
                viol = viol + 1;
                $display("checker: undriven io_out bits set at cycle %0d", cyc);
            end
            if (bus.resp_valid && rv_prev) begin
                viol = viol + 1;
                $display("checker: resp_valid two cycles in a row at cycle %0d", cyc);
            end
            if (bus.resp_valid) rv_count = rv_count + 1;
        end
        rv_prev = bus.resp_valid;
    end

    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] last_data = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total = n_total + 1;
        if (act === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic wait_ready(input string name, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 400 && !ok; t++) begin
            @(negedge clk);
            if (bus.req_ready) ok = 1'b1;
        end
        if (!ok) chk({name, "_ready_timeout"}, 64'(0), 64'(1));
    endtask

    // One read: handshake, bounded wait for the response, data/latency/bus checks.
    task automatic do_read(input logic [23:0] a, input logic [31:0] exp, input string name);
        bit    ok;
        int    hs;
        int    t;
        bit    hold_ok;
        xfer_t x;
        wait_ready(name, ok);
        if (!ok) return;
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        hs = cyc;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_addr  = 24'($urandom);
        hold_ok = 1'b1;
        t = 0;
        while (!bus.resp_valid && t < 400) begin
            if (bus.resp_data !== last_data) hold_ok = 1'b0;
            @(negedge clk);
            t++;
        end
        if (!bus.resp_valid) begin
            chk({name, "_resp_timeout"}, 64'(0), 64'(1));
            return;
        end
        chk({name, "_latency"}, 64'(cyc - hs), 64'(LAT));
        chk({name, "_data"}, 64'(bus.resp_data), 64'(exp));
        chk({name, "_data_hold"}, 64'(hold_ok), 64'(1));
        last_data = exp;
        if (log_q.size() == 0) begin
            chk({name, "_bus_log"}, 64'(0), 64'(1));
        end else begin
            x = log_q.pop_front();
            chk({name, "_cmd_addr"}, 64'(x.bits), 64'({8'h6B, a}));
            chk({name, "_sck_count"}, 64'(x.nsck), 64'(NSCK));
        end
    endtask

    // Release reset and check the wake-up sequence up to the first req_ready.
    task automatic wake_seq(input string name);
        int r;
        int csn_low;
        int rv0;
        bit ok;
        xfer_t x;
        log_q.delete();
        @(negedge clk);
        reset = 1'b0;
        r = cyc;
        rv0 = rv_count;
        csn_low = 0;
        ok = 1'b0;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge clk);
            if (!flash_csn) csn_low++;
            if (bus.req_ready) ok = 1'b1;
        end
        chk({name, "_ready_delay"}, 64'(ok ? cyc - r : -1), 64'(INITW + 16 + 4));
        chk({name, "_csn_low_cycles"}, 64'(csn_low), 64'(16));
        chk({name, "_no_resp"}, 64'(rv_count - rv0), 64'(0));
        if (log_q.size() != 1) begin
            chk({name, "_wake_xfers"}, 64'(log_q.size()), 64'(1));
        end else begin
            x = log_q.pop_front();
            chk({name, "_wake_cmd"}, 64'({x.nsck[7:0], x.bits[7:0]}), 64'({8'd8, 8'hAB}));
        end
    endtask

    typedef struct {
        logic [23:0] addr;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[6];

    initial begin
        bit          ok;
        int          rvc;
        int          rv0;
        int          t;
        logic [23:0] a;
        logic [23:0] b;
        xfer_t       x;

        vecs[0] = '{24'h012345, 32'h44332211};
        vecs[1] = '{24'h012346, {mem_byte(24'h012349), 24'h443322}};
        vecs[2] = '{24'h000000, expect_word(24'h000000)};
        vecs[3] = '{24'hFFFFFD, expect_word(24'hFFFFFD)};
        vecs[4] = '{24'h800000, expect_word(24'h800000)};
        vecs[5] = '{24'h00ABCD, expect_word(24'h00ABCD)};

        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            64'({flash_csn, flash_sck, flash_io_oe, flash_io_out, bus.req_ready,
                 bus.resp_valid, bus.resp_data}),
            64'({1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 32'h0}));
        wake_seq("boot");

        for (int i = 0; i < 6; i++) do_read(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i));

        // Back-to-back with req_valid held high; address changes once the first result is out.
        a = 24'h3C5A01;
        b = 24'h0F00F7;
        wait_ready("b2b", ok);
        if (ok) begin
            bus.req_valid = 1'b1;
            bus.req_addr  = a;
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!bus.resp_valid && t < 400);
            chk("b2b_first_data", 64'(bus.resp_data), 64'(expect_word(a)));
            bus.req_addr = b;
            rvc = cyc;
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (flash_csn && t < 50);
            // Cycles strictly between the response pulse and the next chip-select fall.
            chk("b2b_gap_cycles", 64'(cyc - rvc - 1), 64'(5));
            bus.req_valid = 1'b0;
            t = 0;
            while (!bus.resp_valid && t < 400) begin
                @(negedge clk);
                t++;
            end
            chk("b2b_second_data", 64'(bus.resp_data), 64'(expect_word(b)));
            last_data = expect_word(b);
            chk("b2b_xfers", 64'(log_q.size()), 64'(2));
            if (log_q.size() == 2) begin
                x = log_q.pop_front();
                chk("b2b_first_addr", 64'(x.bits), 64'({8'h6B, a}));
                x = log_q.pop_front();
                chk("b2b_second_addr", 64'(x.bits), 64'({8'h6B, b}));
            end
        end

        // Reset pulsed in the middle of the data phase.
        a = 24'h5A5A5A;
        wait_ready("rst_mid", ok);
        if (ok) begin
            bus.req_valid = 1'b1;
            bus.req_addr  = a;
            @(negedge clk);
            bus.req_valid = 1'b0;
            t = 0;
            while (rise_cnt <= 34 + DUMMY && t < 300) begin
                @(negedge clk);
                t++;
            end
            chk("rst_mid_reached_data", 64'(rise_cnt > 34 + DUMMY), 64'(1));
            rv0 = rv_count;
            reset = 1'b1;
            #1;
            chk("rst_mid_async",
                64'({flash_csn, flash_sck, flash_io_oe, bus.req_ready, bus.resp_valid}),
                64'({1'b1, 1'b0, 4'h0, 1'b0, 1'b0}));
            repeat (2) @(negedge clk);
            wake_seq("rst_mid");
            chk("rst_mid_no_resp_total", 64'(rv_count - rv0), 64'(0));
            last_data = '0;
            do_read(a, expect_word(a), "after_rst");
        end

        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            a = 24'($urandom);
            do_read(a, expect_word(a), $sformatf("rnd%0d", i));
        end

        chk("checker_violations", 64'(viol), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
